// File: rtl/shr_32_iter_pkg.sv
// Shared definitions for the iterative 32-bit right shifter.
package shr_32_iter_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 5;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Shift v right by 2^k, filling vacated bits with 'fill'.
    function automatic logic [WIDTH-1:0] stage_shr(
        input logic [WIDTH-1:0] v,
        input logic [CNT_W-1:0] k,
        input logic             fill
    );
        logic [WIDTH-1:0] r;
        case (k)
            3'd0:    r = {fill, v[31:1]};
            3'd1:    r = {{2{fill}}, v[31:2]};
            3'd2:    r = {{4{fill}}, v[31:4]};
            3'd3:    r = {{8{fill}}, v[31:8]};
            3'd4:    r = {{16{fill}}, v[31:16]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mux_32.sv
// 32-bit 2:1 multiplexer.
module mux_32
    import shr_32_iter_pkg::*;
(
    input  logic             sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    output logic [WIDTH-1:0] y_o
);

    // Select d1 when sel is high, else d0.
    always_comb begin
        y_o = sel_i ? d1_i : d0_i;
    end

endmodule

// File: rtl/shr_32_iter.sv
// Iterative 32-bit logical/arithmetic right shifter: one binary-weighted
// stage per cycle, fixed five-cycle latency, valid/ready handshakes.
module shr_32_iter
    import shr_32_iter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       shamt_q, shamt_d;
    logic             arith_q, arith_d;
    logic             over_q, over_d;

    logic             fill_bit;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] stage_val;

    // In arithmetic mode work_q[31] never changes while shifting, so it is
    // still the original a[31] and serves both stage fill and overshift fill.
    always_comb begin
        fill_bit = arith_q & work_q[31];
        shifted  = stage_shr(work_q, cnt_q, fill_bit);
    end

    mux_32 u_stage_mux (
        .sel_i (shamt_q[cnt_q]),
        .d0_i  (work_q),
        .d1_i  (shifted),
        .y_o   (stage_val)
    );

    // State, datapath and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            shamt_q <= '0;
            arith_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            shamt_q <= shamt_d;
            arith_q <= arith_d;
            over_q  <= over_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        shamt_d   = shamt_q;
        arith_d   = arith_q;
        over_d    = over_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = a;
                    shamt_d = b[4:0];
                    arith_d = arith;
                    over_d  = |b[31:5];
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_W'(STAGES - 1)) begin
                    state_d = ST_DONE;
                    work_d  = over_q ? {WIDTH{fill_bit}} : stage_val;
                end else begin
                    work_d  = stage_val;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out = work_q;
    end

endmodule

// File: tb/tb_shr_32_iter.sv
// Self-checking bench for shr_32_iter: directed cases plus randomized
// operations compared against a plain-arithmetic reference.
module tb_shr_32_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    shr_32_iter dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shr(input logic [31:0] va, input logic [31:0] vb, input logic varith);
        if (varith)
            return 32'($signed(va) >>> vb);
        else
            return va >> vb;
    endfunction

    // Issue one operation from IDLE (called at a negedge), check latency,
    // result, stall stability, and drain back to IDLE.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tarith, input int stall);
        logic [31:0] exp;
        int          lat;
        bit          seen;
        exp = ref_shr(ta, tb_v, tarith);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        arith    = tarith;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a     = $urandom;
        b     = $urandom;
        arith = 1'($urandom_range(0, 1));
        lat   = 0;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            check("in_ready_busy", 32'(in_ready), 32'd0);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        if (!seen) begin
            check("timeout_out_valid", 32'(out_valid), 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'd5);
        check("result", out, exp);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clock);
            @(negedge clock);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_out", out, exp);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rb;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        arith     = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", out, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Directed cases
        run_op(32'h8000_0000, 32'd4, 1'b0, 0);
        run_op(32'h8000_0000, 32'd4, 1'b1, 1);
        run_op(32'h8000_0000, 32'd31, 1'b1, 0);
        run_op(32'hDEAD_BEEF, 32'h0000_0020, 1'b0, 0);
        run_op(32'hDEAD_BEEF, 32'h0000_0020, 1'b1, 0);
        run_op(32'h1234_5678, 32'd0, 1'b0, 3);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'hF000_000F, 32'd31, 1'b0, 0);

        // Reset during stage 2 of an operation
        a        = 32'hFFFF_FFFF;
        b        = 32'd1;
        arith    = 1'b0;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out", out, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("postrst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(32'hA5A5_5A5A, 32'd7, 1'b1, 1);

        // Randomized operations
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 9) == 0)
                rb = $urandom;
            else
                rb = $urandom_range(0, 40);
            run_op($urandom, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shr_32_iter.md
SHR_32_ITER -- requirements
Module: shr_32_iter

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits, shift stages fixed at 5.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 in_valid  input  1  request present on a, b, arith.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a  input  32  operand to shift right.
REQ-007 b  input  32  shift amount, unsigned, full 32 bits significant.
REQ-008 arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-009 out_valid  output  1  out holds a completed result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out  output  32  shift result; held stable while out_valid=1 and out_ready=0.

Function
REQ-012 States SHALL be IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 Accept: in_valid=1 and in_ready=1 at an edge captures a into the working register, b and arith into holding registers, clears stage counter to 0, and moves IDLE->SHIFT.
REQ-014 Overshift: at accept, the block SHALL latch over=1 when any of b[31:5] is 1, else over=0.
REQ-015 SHIFT: each cycle applies stage k (k=0..4): working register shifted right by 2^k when b[k]=1, else unchanged; vacated bits filled with 0 (arith=0) or working-register bit 31 (arith=1).
REQ-016 The stage counter SHALL increment by one per SHIFT cycle; after stage 4, SHIFT->DONE.
REQ-017 On the SHIFT->DONE edge, if over=1, out SHALL load 32'h00000000 (arith=0) or 32 copies of the original a[31] (arith=1) instead of the staged value.
REQ-018 Latency SHALL be exactly 5 cycles from the accept edge to out_valid=1, independent of b (including b=0).
REQ-019 DONE->IDLE when out_ready=1; with out_ready=0 the block SHALL remain in DONE with out unchanged.
REQ-020 in_valid in SHIFT or DONE SHALL be ignored; a, b, arith changes after accept SHALL NOT affect the result in flight.
REQ-021 The block SHALL hold at most one operation; no new accept in the same cycle as DONE->IDLE (in_ready rises the cycle after).
REQ-022 Result SHALL equal a >> b (logical) or $signed(a) >>> b (arithmetic) for every 32-bit a, b.

Reset
REQ-023 reset=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, out=0, stage counter=0, over=0, regardless of clock.
REQ-024 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no out_valid pulse after release.
REQ-025 After reset deasserts, the first rising edge with in_valid=1 SHALL be a valid accept.

Structure
REQ-026 A shared package SHALL hold WIDTH=32, STAGES=5, and the IDLE/SHIFT/DONE state encoding.
REQ-027 Stage selection SHALL reuse the existing 32-bit 2:1 mux module mux_32 (select = b[k] for the active stage); no other sub-module.
REQ-028 One working register, one stage counter (3 bits), and one state register; no combinational path from in_valid to out_valid.

Verification
REQ-029 a=32'h80000000, b=4, arith=0 -> out=32'h08000000, out_valid exactly 5 cycles after accept.
REQ-030 a=32'h80000000, b=4, arith=1 -> out=32'hF8000000; same a, b=31, arith=1 -> out=32'hFFFFFFFF.
REQ-031 a=32'hDEADBEEF, b=32'h00000020, arith=0 -> out=0; arith=1 -> out=32'hFFFFFFFF (overshift path).
REQ-032 a=32'h12345678, b=0 -> out=32'h12345678 after 5 cycles; out_ready held 0 for 3 cycles -> out and out_valid stable, in_ready=0 throughout.
REQ-033 Reset asserted during stage 2 of a=32'hFFFFFFFF, b=1 -> out_valid=0, in_ready=1, out=0 immediately; no result after release.
REQ-034 Back-to-back: 1000 random a, b (b biased to 0..40), arith random, random out_ready stalls -> every result matches REQ-022 model in order.
